// File: rtl/bidir_bus_ctrl_pkg.sv
// Shared definitions for the half-duplex host bus master: FSM encoding and parameter defaults.
// Latency: none (types and constants only).
// Backpressure: n/a.
package bidir_bus_ctrl_pkg;

    localparam int BUS_W_DEF       = 8;
    localparam int LEN_W_DEF       = 8;
    localparam int TURN_CYCLES_DEF = 1;

    // IDLE: bus parked with tx_oe high; WRITE: host streams bytes onto the bus;
    // RD_TURN: bus released, waiting for Memory to take it; READ: sampling Memory's bytes
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RD_TURN = 2'd2,
        ST_READ    = 2'd3
    } state_e;

    // Width of the turnaround down-counter; it holds TURN_CYCLES-1 and never needs less than 1 bit
    function automatic int turn_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/bidir_bus_ctrl_pad.sv
// Tri-state pad for the shared data bus plus the registered sample path for read data.
// Latency: drive is combinational from the registered enable/data; sampled data appears 1 cycle after sample_en_i.
// Backpressure: none; the host only drives while drive_en_i is high, otherwise the bus floats.
module bidir_bus_ctrl_pad #(
    parameter int BUS_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             drive_en_i,
    input  logic [BUS_W-1:0] drive_dat_i,
    input  logic             sample_en_i,
    output logic [BUS_W-1:0] sample_dat_o,
    inout  wire  [BUS_W-1:0] data_io
);

    logic [BUS_W-1:0] sample_q;
    logic [BUS_W-1:0] sample_d;

    // Host drive is gated purely by the registered enable, so the pad never glitches onto the bus
    assign data_io = drive_en_i ? drive_dat_i : {BUS_W{1'bz}};

    // Capture the bus only on cycles the controller marks as read samples, otherwise hold
    always_comb begin
        sample_d = sample_q;
        if (sample_en_i) begin
            sample_d = data_io;
        end
    end

    // Read data register, cleared by reset so rd_data_o starts at zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample_dat_o = sample_q;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Host-side master for the 8-bit half-duplex Memory bus: write stream out, read bursts back.
// Latency: written byte on the bus 1 cycle after acceptance; first read sample TURN_CYCLES+1 cycles after launch.
// Backpressure: wr_ready_o only in WRITE; read data has no backpressure; extra read requests while one is outstanding are dropped.
module bidir_bus_ctrl
    import bidir_bus_ctrl_pkg::*;
#(
    parameter int BUS_W       = BUS_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [BUS_W-1:0] wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic             rd_req_i,
    input  logic [LEN_W-1:0] rd_len_i,
    output logic [BUS_W-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             tx_oe_o,
    inout  wire  [BUS_W-1:0] data_io
);

    localparam int              TURN_W    = turn_w(TURN_CYCLES);
    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);

    state_e           state_q, state_d;
    logic             rd_pend_q, rd_pend_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [BUS_W-1:0] data_q, data_d;
    logic             drive_en_q, drive_en_d;
    logic             tx_oe_q, tx_oe_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             sample_en;
    logic [LEN_W-1:0] eff_len;

    // Next-state and registered-output decode; the bus idles released (tx_oe high, no host drive)
    // unless a fresh byte is accepted this cycle, which keeps turnaround safe by construction
    always_comb begin
        state_d    = state_q;
        rd_pend_d  = rd_pend_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        turn_d     = turn_q;
        data_d     = data_q;
        drive_en_d = 1'b0;
        tx_oe_d    = 1'b1;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        sample_en  = 1'b0;
        // A latched request keeps its own length; a new pulse arriving alongside it is dropped
        eff_len    = rd_pend_q ? len_q : rd_len_i;

        unique case (state_q)
            ST_IDLE: begin
                // Reads take priority over a waiting write so Memory sees the read first
                if (rd_pend_q || rd_req_i) begin
                    rd_pend_d = 1'b0;
                    len_d     = eff_len;
                    if (eff_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RD_TURN;
                        turn_d  = TURN_LOAD;
                    end
                end else if (wr_valid_i) begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Reads requested mid-burst wait until the write stream pauses
                if (rd_req_i && !rd_pend_q) begin
                    rd_pend_d = 1'b1;
                    len_d     = rd_len_i;
                end
                if (wr_valid_i) begin
                    data_d     = wr_data_i;
                    drive_en_d = 1'b1;
                    tx_oe_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_TURN: begin
                if (turn_q == '0) begin
                    state_d = ST_READ;
                    cnt_d   = len_q;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end

            ST_READ: begin
                sample_en  = 1'b1;
                rd_valid_d = 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counters, pending-read latch and registered bus controls; reset aborts any burst silently
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rd_pend_q  <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            turn_q     <= '0;
            data_q     <= '0;
            drive_en_q <= 1'b0;
            tx_oe_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            turn_q     <= turn_d;
            data_q     <= data_d;
            drive_en_q <= drive_en_d;
            tx_oe_q    <= tx_oe_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    bidir_bus_ctrl_pad #(
        .BUS_W (BUS_W)
    ) u_pad (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .drive_en_i   (drive_en_q),
        .drive_dat_i  (data_q),
        .sample_en_i  (sample_en),
        .sample_dat_o (rd_data_o),
        .data_io      (data_io)
    );

    assign wr_ready_o = (state_q == ST_WRITE);
    assign busy_o     = (state_q != ST_IDLE);
    assign tx_oe_o    = tx_oe_q;
    assign rd_valid_o = rd_valid_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
module tb_bidir_bus_ctrl;

    localparam int T = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wv, rq;
    logic [7:0] wd, rl;
    logic       wr_ready, rd_valid, done, busy, tx_oe;
    logic [7:0] rd_data;
    wire  [7:0] data_io;
    logic [7:0] mem_drv;

    // Memory side of the bus: drives whenever the host has handed the bus over
    assign data_io = tx_oe ? mem_drv : 8'bz;

    bidir_bus_ctrl #(.BUS_W(8), .LEN_W(8), .TURN_CYCLES(T)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_data_i  (wd),
        .wr_valid_i (wv),
        .wr_ready_o (wr_ready),
        .rd_req_i   (rq),
        .rd_len_i   (rl),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .done_o     (done),
        .busy_o     (busy),
        .tx_oe_o    (tx_oe),
        .data_io    (data_io)
    );

    int errors = 0;
    int checks = 0;

    // Memory contents: captured writes land at wp, read bursts are served from rp
    logic [7:0] mem [0:1023];
    int wp, rp;

    // Reference model: 0 idle, 1 writing, 2 read burst (launched at rd_launch, last sample at rd_end)
    int   m_status;
    bit   m_pend;
    int   m_plen;
    int   rd_launch, rd_end, edge_n;
    logic e_tx_oe, e_drive, e_rvld, e_done;
    logic [7:0] e_bus, e_rdat;

    int n_rv, n_done, n_low, base;
    logic [7:0] rd_seen [$];
    logic [7:0] burst [4];
    logic [7:0] rdexp [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs presented during the cycle
    task automatic model_edge();
        int len;
        if (rst) begin
            m_status = 0; m_pend = 0;
            e_tx_oe = 1'b1; e_drive = 1'b0; e_rvld = 1'b0; e_done = 1'b0; e_rdat = 8'h00;
        end else begin
            e_rvld = 1'b0; e_done = 1'b0; e_tx_oe = 1'b1; e_drive = 1'b0;
            case (m_status)
                0: begin
                    if (m_pend || rq) begin
                        len = m_pend ? m_plen : int'(rl);
                        m_pend = 0;
                        if (len == 0) begin
                            e_done = 1'b1;
                        end else begin
                            m_status  = 2;
                            rd_launch = edge_n;
                            rd_end    = edge_n + T + len;
                        end
                    end else if (wv) begin
                        m_status = 1;
                    end
                end
                1: begin
                    if (rq && !m_pend) begin
                        m_pend = 1;
                        m_plen = int'(rl);
                    end
                    if (wv) begin
                        e_tx_oe = 1'b0; e_drive = 1'b1; e_bus = wd;
                    end else begin
                        m_status = 0;
                    end
                end
                2: begin
                    if (edge_n > rd_launch + T) begin
                        e_rvld = 1'b1;
                        e_rdat = mem[rp & 1023];
                        rp++;
                        if (edge_n == rd_end) begin
                            e_done   = 1'b1;
                            m_status = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock cycle: Memory presents data, outputs checked mid-cycle, then the edge is modelled
    task automatic step();
        bit smp;
        smp = (m_status == 2) && (edge_n + 1 > rd_launch + T) && (edge_n + 1 <= rd_end);
        mem_drv = smp ? mem[rp & 1023] : ~mem[rp & 1023];
        @(negedge clk);
        chk("tx_oe",      32'(tx_oe),    32'(e_tx_oe));
        chk("drive_en",   32'(dut.drive_en_q), 32'(e_drive));
        chk("wr_ready",   32'(wr_ready), 32'(m_status == 1));
        chk("busy",       32'(busy),     32'(m_status != 0));
        chk("rd_valid",   32'(rd_valid), 32'(e_rvld));
        chk("done",       32'(done),     32'(e_done));
        chk("rd_data",    32'(rd_data),  32'(e_rdat));
        chk("contention", 32'(dut.drive_en_q & tx_oe), 32'(0));
        if (e_drive) chk("bus_byte", 32'(data_io), 32'(e_bus));
        if (tx_oe === 1'b0) begin
            mem[wp & 1023] = data_io;
            wp++;
            n_low++;
        end
        if (rd_valid === 1'b1) begin
            n_rv++;
            rd_seen.push_back(rd_data);
        end
        if (done === 1'b1) n_done++;
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic clr();
        n_rv = 0; n_done = 0; n_low = 0; base = wp;
        rd_seen.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        wp = 0; rp = 0; edge_n = 0; rd_launch = 0; rd_end = 0;
        m_status = 0; m_pend = 0; m_plen = 0;
        e_tx_oe = 1'b1; e_drive = 1'b0; e_rvld = 1'b0; e_done = 1'b0; e_rdat = 8'h00; e_bus = 8'h00;
        rst = 1'b1; wv = 1'b0; rq = 1'b0; wd = 8'h00; rl = 8'h00; mem_drv = 8'h00;
        @(posedge clk);
        #1;
        step(); step();
        rst = 1'b0;

        // Back-to-back write burst
        clr();
        burst = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wv = 1'b1; wd = 8'hAA; step();
        for (int i = 0; i < 4; i++) begin
            wd = burst[i];
            step();
        end
        wv = 1'b0; step(); step(); step();
        chk("burst_low_cycles", 32'(n_low), 32'(4));
        chk("burst_captured", 32'(wp - base), 32'(4));
        for (int i = 0; i < 4; i++) chk("burst_mem", 32'(mem[(base + i) & 1023]), 32'(burst[i]));

        // Reset held three cycles in the middle of a write
        wv = 1'b1; wd = 8'h3C; step(); step(); wd = 8'h4D; step();
        rst = 1'b1; step(); step(); step();
        rst = 1'b0; wv = 1'b0; step(); step();

        // Write with a one-cycle gap
        clr();
        wv = 1'b1; wd = 8'hAA; step(); step();
        wv = 1'b0; step();
        wv = 1'b1; wd = 8'hBB; step(); step();
        wv = 1'b0; step(); step(); step();
        chk("gap_low_cycles", 32'(n_low), 32'(2));
        chk("gap_captured", 32'(wp - base), 32'(2));
        chk("gap_mem0", 32'(mem[base & 1023]), 32'(8'hAA));
        chk("gap_mem1", 32'(mem[(base + 1) & 1023]), 32'(8'hBB));

        // Write 11,22,33 then read them back
        rp = wp;
        rdexp = '{8'h11, 8'h22, 8'h33};
        wv = 1'b1; wd = 8'h11; step();
        for (int i = 0; i < 3; i++) begin
            wd = rdexp[i];
            step();
        end
        wv = 1'b0; step();
        clr();
        rq = 1'b1; rl = 8'd3; step();
        rq = 1'b0;
        repeat (8) step();
        chk("read3_count", 32'(n_rv), 32'(3));
        chk("read3_done", 32'(n_done), 32'(1));
        chk("read3_len", 32'(rd_seen.size()), 32'(3));
        for (int i = 0; i < 3; i++)
            chk("read3_byte", 32'((i < rd_seen.size()) ? rd_seen[i] : 8'h00), 32'(rdexp[i]));

        // Read request and write valid together in IDLE
        clr();
        rq = 1'b1; rl = 8'd2; wv = 1'b1; wd = 8'h5A; step();
        rq = 1'b0;
        repeat (8) step();
        wv = 1'b0; step(); step(); step();
        chk("simul_read_count", 32'(n_rv), 32'(2));
        chk("simul_done", 32'(n_done), 32'(1));

        // Zero-length read
        clr();
        rq = 1'b1; rl = 8'd0; step();
        rq = 1'b0;
        repeat (4) step();
        chk("len0_valid", 32'(n_rv), 32'(0));
        chk("len0_done", 32'(n_done), 32'(1));

        // Maximum-length read
        clr();
        rq = 1'b1; rl = 8'd255; step();
        rq = 1'b0;
        repeat (262) step();
        chk("len255_valid", 32'(n_rv), 32'(255));
        chk("len255_done", 32'(n_done), 32'(1));

        // Random traffic against the model
        repeat (3000) begin
            rst = ($urandom_range(0, 499) == 0);
            wv  = ($urandom_range(0, 3) != 0);
            wd  = 8'($urandom);
            rq  = ($urandom_range(0, 29) == 0);
            rl  = 8'($urandom_range(0, 6));
            step();
        end
        rst = 1'b0; wv = 1'b0; rq = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
